// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Write-back select codes shared by the pipeline stage selectors
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int SEL_ALU       = 0;
    localparam int SEL_MEM       = 1;
    localparam int SEL_PC8       = 2;
    localparam int SEL_HILO      = 3;
    localparam int SEL_CP0       = 4;
    localparam int SEL_NUM_LEGAL = 5;

endpackage
`default_nettype wire

// File: rtl/sel_mux.sv
`default_nettype none
// ============================================================================
// Module      : sel_mux
// Description : N-way selector; undefined codes give zero and flag illegal
// Revision    : 1.0 - initial release
// ============================================================================
module sel_mux #(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 8,
    parameter int NUM_LEGAL = 5,
    parameter int SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_illegal
);

    // A code is legal only if it names an existing port below NUM_LEGAL.
    always_comb begin
        o_data    = '0;
        o_illegal = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if ((k < NUM_LEGAL) && (i_sel == SEL_W'(k))) begin
                o_data    = i_data[k*WIDTH +: WIDTH];
                o_illegal = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage_sel_reg.sv
`default_nettype none
// ============================================================================
// Module      : stage_sel_reg
// Description : Result selector fused with a stall/flush pipeline register
// Revision    : 1.0 - initial release
// ============================================================================
module stage_sel_reg
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 8,
    parameter int NUM_LEGAL = SEL_NUM_LEGAL,
    parameter int CNT_W     = 8,
    parameter int SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    clr_err,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    err_sticky,
    output logic [CNT_W-1:0]        err_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [WIDTH-1:0] w_sel_data;
    logic             w_illegal;
    logic             w_load;
    logic             w_accept;

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SEL_W-1:0] r_sel;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    sel_mux #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN),
        .NUM_LEGAL (NUM_LEGAL),
        .SEL_W     (SEL_W)
    ) u_sel_mux (
        .i_data    (in_data),
        .i_sel     (sel),
        .o_data    (w_sel_data),
        .o_illegal (w_illegal)
    );

    assign w_load   = !flush && !stall;
    assign w_accept = w_load && in_valid && w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sel   <= '0;
        end else if (flush) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sel   <= '0;
        end else if (!stall) begin
            r_data  <= w_sel_data;
            r_valid <= in_valid;
            r_sel   <= sel;
        end
    end

    // A new illegal event outranks a simultaneous clear, restarting the count at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_sticky <= 1'b1;
            if (clr_err)
                r_count <= CNT_W'(1);
            else if (r_count != c_cnt_max)
                r_count <= r_count + CNT_W'(1);
        end else if (clr_err) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end
    end

    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign out_sel    = r_sel;
    assign err_sticky = r_sticky;
    assign err_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_stage_sel_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_sel_reg
// Description : Directed vector bench for stage_sel_reg and a parameter sweep
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_sel_reg;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance: default parameters
    logic [8*32-1:0] m_data;
    logic [2:0]      m_sel;
    logic            m_valid, m_stall, m_flush, m_clr;
    logic [31:0]     m_out;
    logic            m_out_valid;
    logic [2:0]      m_out_sel;
    logic            m_sticky;
    logic [7:0]      m_count;

    stage_sel_reg u_main (
        .clk(clk), .reset(reset), .in_data(m_data), .sel(m_sel),
        .in_valid(m_valid), .stall(m_stall), .flush(m_flush), .clr_err(m_clr),
        .out_data(m_out), .out_valid(m_out_valid), .out_sel(m_out_sel),
        .err_sticky(m_sticky), .err_count(m_count)
    );

    // Saturation instance: 2-bit counter
    logic [8*32-1:0] s_data;
    logic [2:0]      s_sel;
    logic            s_valid, s_stall, s_flush, s_clr;
    logic [31:0]     s_out;
    logic            s_out_valid;
    logic [2:0]      s_out_sel;
    logic            s_sticky;
    logic [1:0]      s_count;

    stage_sel_reg #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_data(s_data), .sel(s_sel),
        .in_valid(s_valid), .stall(s_stall), .flush(s_flush), .clr_err(s_clr),
        .out_data(s_out), .out_valid(s_out_valid), .out_sel(s_out_sel),
        .err_sticky(s_sticky), .err_count(s_count)
    );

    // Small instance: no illegal codes exist
    logic [15:0] p_data;
    logic        p_sel;
    logic        p_valid, p_stall, p_flush, p_clr;
    logic [7:0]  p_out;
    logic        p_out_valid;
    logic        p_out_sel;
    logic        p_sticky;
    logic [7:0]  p_count;

    stage_sel_reg #(.WIDTH(8), .NUM_IN(2), .NUM_LEGAL(2)) u_small (
        .clk(clk), .reset(reset), .in_data(p_data), .sel(p_sel),
        .in_valid(p_valid), .stall(p_stall), .flush(p_flush), .clr_err(p_clr),
        .out_data(p_out), .out_valid(p_out_valid), .out_sel(p_out_sel),
        .err_sticky(p_sticky), .err_count(p_count)
    );

    typedef struct {
        logic [2:0]  sel;
        logic        valid, stall, flush, clr;
        logic [31:0] e_data;
        logic        e_valid;
        logic [2:0]  e_sel;
        logic        e_sticky;
        logic [7:0]  e_count;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main_zero(input string tag);
        check({tag, " data"},   m_out, 32'h0);
        check({tag, " valid"},  {31'h0, m_out_valid}, 32'h0);
        check({tag, " sel"},    {29'h0, m_out_sel}, 32'h0);
        check({tag, " sticky"}, {31'h0, m_sticky}, 32'h0);
        check({tag, " count"},  {24'h0, m_count}, 32'h0);
    endtask

    function automatic vec_t mk(input logic [2:0] sel, input logic valid, input logic stall,
                                input logic flush, input logic clr, input logic [31:0] ed,
                                input logic ev, input logic [2:0] es, input logic est,
                                input logic [7:0] ec);
        vec_t v;
        v.sel = sel; v.valid = valid; v.stall = stall; v.flush = flush; v.clr = clr;
        v.e_data = ed; v.e_valid = ev; v.e_sel = es; v.e_sticky = est; v.e_count = ec;
        return v;
    endfunction

    logic [7:0] exp_pd;
    logic       exp_pv;
    logic       exp_ps;

    initial begin
        for (int k = 0; k < 8; k++) m_data[k*32 +: 32] = 32'h1000 + k;
        s_data = m_data;
        m_sel = 3'd0; m_valid = 1'b0; m_stall = 1'b0; m_flush = 1'b0; m_clr = 1'b0;
        s_sel = 3'd0; s_valid = 1'b0; s_stall = 1'b0; s_flush = 1'b0; s_clr = 1'b0;
        p_data = 16'h0; p_sel = 1'b0; p_valid = 1'b0; p_stall = 1'b0; p_flush = 1'b0; p_clr = 1'b0;

        //                sel   v     st    fl    clr   data          ev    esel  est   ecnt
        vecs[0]  = mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 1'b1, 3'd0, 1'b0, 8'd0);
        vecs[1]  = mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1001, 1'b1, 3'd1, 1'b0, 8'd0);
        vecs[2]  = mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1002, 1'b1, 3'd2, 1'b0, 8'd0);
        vecs[3]  = mk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1003, 1'b1, 3'd3, 1'b0, 8'd0);
        vecs[4]  = mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1004, 1'b1, 3'd4, 1'b0, 8'd0);
        vecs[5]  = mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1002, 1'b1, 3'd2, 1'b0, 8'd0);
        vecs[6]  = mk(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1002, 1'b1, 3'd2, 1'b0, 8'd0);
        vecs[7]  = mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1002, 1'b1, 3'd2, 1'b0, 8'd0);
        vecs[8]  = mk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1002, 1'b1, 3'd2, 1'b0, 8'd0);
        vecs[9]  = mk(3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 3'd0, 1'b0, 8'd0);
        vecs[10] = mk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1003, 1'b1, 3'd3, 1'b0, 8'd0);
        vecs[11] = mk(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 3'd6, 1'b1, 8'd1);
        vecs[12] = mk(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 3'd6, 1'b1, 8'd1);
        vecs[13] = mk(3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 3'd6, 1'b1, 8'd1);
        vecs[14] = mk(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 3'd0, 1'b1, 8'd1);
        vecs[15] = mk(3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,    1'b0, 3'd0, 1'b0, 8'd0);
        vecs[16] = mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1001, 1'b0, 3'd1, 1'b0, 8'd0);

        // Power-on reset is asynchronous: outputs clear before any clock edge
        #2 reset = 1'b1;
        #1;
        check_main_zero("por");
        check("por small sticky", {31'h0, p_sticky}, 32'h0);
        check("por sat count", {30'h0, s_count}, 32'h0);
        #7 reset = 1'b0;
        step();

        // Reset in the middle of a cycle clears a loaded value immediately
        m_data[31:0] = 32'hDEADBEEF;
        m_sel = 3'd0; m_valid = 1'b1;
        step();
        check("pre-reset data", m_out, 32'hDEADBEEF);
        #2 reset = 1'b1;
        #1;
        check_main_zero("mid reset");
        #2 reset = 1'b0;
        m_data[31:0] = 32'h1000;
        m_valid = 1'b0;
        step();

        for (int i = 0; i < 17; i++) begin
            m_sel = vecs[i].sel; m_valid = vecs[i].valid; m_stall = vecs[i].stall;
            m_flush = vecs[i].flush; m_clr = vecs[i].clr;
            step();
            check($sformatf("vec%0d data", i),   m_out, vecs[i].e_data);
            check($sformatf("vec%0d valid", i),  {31'h0, m_out_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("vec%0d sel", i),    {29'h0, m_out_sel}, {29'h0, vecs[i].e_sel});
            check($sformatf("vec%0d sticky", i), {31'h0, m_sticky}, {31'h0, vecs[i].e_sticky});
            check($sformatf("vec%0d count", i),  {24'h0, m_count}, {24'h0, vecs[i].e_count});
        end
        m_valid = 1'b0; m_stall = 1'b0; m_flush = 1'b0; m_clr = 1'b0;

        // Saturating 2-bit counter, then clear-vs-event priority
        s_sel = 3'd7; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sat%0d count", i), {30'h0, s_count}, (i < 3) ? i + 1 : 3);
            check($sformatf("sat%0d data", i), s_out, 32'h0);
        end
        s_clr = 1'b1;
        step();
        check("clr+evt count",  {30'h0, s_count}, 32'd1);
        check("clr+evt sticky", {31'h0, s_sticky}, 32'd1);
        s_valid = 1'b0;
        step();
        check("clr count",  {30'h0, s_count}, 32'd0);
        check("clr sticky", {31'h0, s_sticky}, 32'd0);
        s_clr = 1'b0;

        // Small configuration under random stimulus, against a reference model
        exp_pd = p_out; exp_pv = p_out_valid; exp_ps = p_out_sel;
        check("small init data", {24'h0, p_out}, 32'h0);
        for (int i = 0; i < 60; i++) begin
            p_data  = 16'($urandom);
            p_sel   = 1'($urandom_range(0, 1));
            p_valid = 1'($urandom_range(0, 1));
            p_stall = ($urandom_range(0, 3) == 0);
            p_flush = ($urandom_range(0, 5) == 0);
            if (p_flush) begin
                exp_pd = 8'h0; exp_pv = 1'b0; exp_ps = 1'b0;
            end else if (!p_stall) begin
                exp_pd = p_sel ? p_data[15:8] : p_data[7:0];
                exp_pv = p_valid; exp_ps = p_sel;
            end
            step();
            check($sformatf("small%0d data", i),  {24'h0, p_out}, {24'h0, exp_pd});
            check($sformatf("small%0d valid", i), {31'h0, p_out_valid}, {31'h0, exp_pv});
            check($sformatf("small%0d sel", i),   {31'h0, p_out_sel}, {31'h0, exp_ps});
            check($sformatf("small%0d sticky", i), {31'h0, p_sticky}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
